mult8_seq_ctrl: RTL and testbench

- Sequential shift-and-add 8x8 unsigned multiplier controller.
- Time-multiplexes one 8-bit ripple adder with a 9-bit result over 8 iterations. No array multiplier is built.
- Sits between a requester, which supplies operands with a start pulse, and the shared adder datapath. Returns a 16-bit product with a done pulse.

---
 rtl/mult_pkg.sv | 18 +
 rtl/mult8_seq_ctrl_adder8b.sv | 17 +
 rtl/mult8_seq_ctrl.sv | 134 +++++++++++++
 tb/tb_mult8_seq_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the sequential shift-and-add multiplier controller:
// the FSM state encoding and the fixed operand width / iteration count.
// -----------------------------------------------------------------------------
package mult_pkg;

    // 2'b11 is unused and is steered back to IDLE by the FSM default branch.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } mult_state_e;

    localparam int MULT_W    = 8;
    localparam int MULT_ITER = 8;

endpackage : mult_pkg

// File: rtl/mult8_seq_ctrl_adder8b.sv
// -----------------------------------------------------------------------------
// adder8b
// Shared 8-bit ripple adder with a 9-bit result (carry out in s[8]).
// Ports:
//   a  in  8   first addend (ACC in the multiplier)
//   b  in  8   second addend (multiplicand M)
//   s  out 9   a + b, carry in bit 8
// -----------------------------------------------------------------------------
module adder8b (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [8:0] s
);

    assign s = {1'b0, a} + {1'b0, b};

endmodule : adder8b

// File: rtl/mult8_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mult8_seq_ctrl
// Sequential 8x8 unsigned shift-and-add multiplier. One shared 8-bit adder is
// reused for 8 iterations; the product is {ACC,Q} and is registered.
// Ports:
//   clock    in  1   system clock, rising edge
//   reset_n  in  1   asynchronous active-low reset
//   start    in  1   request, sampled only in IDLE
//   A, B     in  8   multiplicand / multiplier, captured on the accepting edge
//   busy     out 1   high from the accepting edge until return to IDLE
//   done     out 1   one-cycle pulse, P valid while high
//   P        out 16  product, held until the next accepted start
// Optional feature (macro MULT_ZERO_BYPASS_EN): a zero operand skips RUN and
// produces the done pulse one cycle after the accept.
// -----------------------------------------------------------------------------
module mult8_seq_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] P
);

    // The adder is hard-wired to 8 bits, so other widths cannot work.
    if (WIDTH != MULT_W || CNT_W != $clog2(WIDTH)) begin : g_bad_width
        $error("mult8_seq_ctrl: only WIDTH=8, CNT_W=3 is supported");
    end

    mult_state_e      state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   t;

    adder8b u_adder (
        .a (acc_q),
        .b (m_q),
        .s (sum)
    );

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        // Add M only when the current multiplier LSB is set; the 9-bit result
        // is then shifted right so the carry lands in ACC[7].
        t       = q_q[0] ? sum : {1'b0, acc_q};

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    m_d     = A;
                    q_d     = B;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
`ifdef MULT_ZERO_BYPASS_EN
                    if (A == '0 || B == '0) begin
                        q_d     = '0;
                        state_d = DONE;
                    end
`endif
                end
            end
            RUN: begin
                acc_d = t[WIDTH:1];
                q_d   = {t[0], q_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(MULT_ITER - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                // Normal entry raises done on the entering edge; the bypass
                // entry arrives with done low and raises it one edge later.
                if (done_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign P    = {acc_q, q_q};

endmodule : mult8_seq_ctrl

// File: tb/tb_mult8_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mult8_seq_ctrl
// Self-checking bench for mult8_seq_ctrl: a vector table of operand pairs with
// expected products and done latency, plus hand-written sequences for held
// start, mid-run reset and back-to-back operation. Honours MULT_ZERO_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_mult8_seq_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        busy;
    logic        done;
    logic [15:0] P;

`ifdef MULT_ZERO_BYPASS_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 8;
`endif

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp_p;
        int          lat;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_q[$];
    logic        done_prev = 1'b0;
    int          done_seen = 0;

    always #5 clock = ~clock;

    mult8_seq_ctrl dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .P       (P)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // done must never stay high for two consecutive cycles.
    always @(negedge clock) begin
        if (done) begin
            done_seen++;
            n_tests++;
            if (done_prev) begin
                n_fail++;
                $display("FAIL done_width: got 2 consecutive cycles expected 1");
            end
        end
        done_prev <= done;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Wait for IDLE, pulse start for one edge, then confirm busy rose.
    task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp_p);
        int g = 0;
        while (busy && g < 50) begin
            tick();
            g++;
        end
        if (busy) check("idle_timeout", 1, 0);
        A     = a;
        B     = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_on_accept", int'(busy), 1);
        exp_q.push_back(exp_p);
    endtask

    // Count edges from the accept edge until done; compare latency and product.
    task automatic wait_done(input int lat, input string nm);
        int          c = 0;
        logic [15:0] e;
        while (!done && c < 40) begin
            tick();
            c++;
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        if (!done) begin
            check({nm, "_timeout"}, 0, 1);
            return;
        end
        check({nm, "_latency"}, c, lat);
        check({nm, "_P"}, int'(P), int'(e));
        check({nm, "_busy_in_done"}, int'(busy), 1);
        tick();
        check({nm, "_done_fall"}, int'(done), 0);
        check({nm, "_busy_fall"}, int'(busy), 0);
        check({nm, "_P_held"}, int'(P), int'(e));
    endtask

    initial begin
        vec_t vecs[7];
        int   c;
        int   seen0;

        vecs[0] = '{a: 8'd13,  b: 8'd11,  exp_p: 16'd143,   lat: 8};
        vecs[1] = '{a: 8'd255, b: 8'd255, exp_p: 16'd65025, lat: 8};
        vecs[2] = '{a: 8'd0,   b: 8'd200, exp_p: 16'd0,     lat: ZLAT};
        vecs[3] = '{a: 8'd200, b: 8'd0,   exp_p: 16'd0,     lat: ZLAT};
        vecs[4] = '{a: 8'd1,   b: 8'd1,   exp_p: 16'd1,     lat: 8};
        vecs[5] = '{a: 8'd128, b: 8'd2,   exp_p: 16'd256,   lat: 8};
        vecs[6] = '{a: 8'd255, b: 8'd1,   exp_p: 16'd255,   lat: 8};

        reset_n = 1'b0;
        start   = 1'b0;
        A       = 8'd0;
        B       = 8'd0;
        tick();
        tick();
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_P", int'(P), 0);
        reset_n = 1'b1;
        tick();

        // Table-driven operand pairs.
        for (int i = 0; i < 7; i++) begin
            accept(vecs[i].a, vecs[i].b, vecs[i].exp_p);
            wait_done(vecs[i].lat, $sformatf("vec%0d", i));
        end

        // start held high: operands changed mid-run must not matter.
        A     = 8'd3;
        B     = 8'd5;
        start = 1'b1;
        c = 0;
        while (!busy && c < 20) begin
            tick();
            c++;
        end
        check("held_accept", int'(busy), 1);
        c = 0;
        while (!done && c < 40) begin
            tick();
            c++;
            if (c == 2) begin
                A = 8'd7;
                B = 8'd7;
            end
        end
        check("held_latency", c, 8);
        check("held_P1", int'(P), 15);
        A = 8'd3;
        B = 8'd5;
        c = 0;
        tick();
        c++;
        while (!done && c < 40) begin
            tick();
            c++;
        end
        check("held_period", c, 10);
        check("held_P2", int'(P), 15);
        start = 1'b0;
        tick();
        tick();

        // Mid-run asynchronous reset during 100*100.
        accept(8'd100, 8'd100, 16'd10000);
        exp_q.delete();
        for (int i = 0; i < 4; i++) tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_P", int'(P), 0);
        tick();
        reset_n = 1'b1;
        seen0 = done_seen;
        for (int i = 0; i < 15; i++) tick();
        check("abort_no_done", done_seen - seen0, 0);
        accept(8'd2, 8'd3, 16'd6);
        wait_done(8, "after_abort");

        // Back-to-back: request the next operation as soon as done is seen.
        accept(8'd10, 8'd10, 16'd100);
        c = 0;
        while (!done && c < 40) begin
            tick();
            c++;
        end
        check("b2b_P1", int'(P), int'(exp_q.pop_front()));
        A     = 8'd12;
        B     = 8'd12;
        start = 1'b1;
        tick();
        check("b2b_P1_held", int'(P), 100);
        c = 0;
        while (!busy && c < 20) begin
            tick();
            c++;
        end
        start = 1'b0;
        check("b2b_accept", int'(busy), 1);
        exp_q.push_back(16'd144);
        wait_done(8, "b2b2");

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_mult8_seq_ctrl
